mat_chain_ctrl: RTL and testbench

Sequencer that drives the shared `mat_mult` unit to form the ordered product P = M0·M1·…·M(L-1) of a stream of up to MAX_LEN N×N matrices, such as a joint-transform chain for the IK solver. It accepts matrices over a valid/ready stream and feeds the running product and the next matrix to `mat_mult`. It waits the unit's fixed latency, folds the result back, and presents the final product with a one-cycle done pulse. It sits between the IK control logic and the `mat_mult` instance and is the only master of that instance.

---
 rtl/mat_chain_pkg.sv | 31 +++
 rtl/mat_chain_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mat_chain_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_chain_pkg.sv
// Shared types and defaults for the matrix-chain sequencer.
package mat_chain_pkg;

  localparam int unsigned DefN      = 6;
  localparam int unsigned DefW      = 48;
  localparam int unsigned DefMaxLen = 6;
  localparam int unsigned DefMmLat  = 4;

  typedef logic [DefN-1:0][DefN-1:0][DefW-1:0] mat_t;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StFetch,
    StMul,
    StWait,
    StDone
  } chain_state_t;

  // Identity at the default matrix size.
  function automatic mat_t identity_mat();
    mat_t m;
    m = '0;
    for (int i = 0; i < int'(DefN); i++) begin
      m[i][i] = DefW'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/mat_chain_ctrl.sv
// Sequencer folding a stream of matrices through the shared mat_mult unit.
// Running product lives in mm_dataa; each multiply is MUL + WAIT, where the
// last WAIT cycle drops mm_en and captures mm_result (MM_LAT after MUL).
module mat_chain_ctrl
  import mat_chain_pkg::*;
#(
  parameter int unsigned N       = DefN,
  parameter int unsigned W       = DefW,
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned MM_LAT  = DefMmLat,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LW-1:0]                 len,
  input  logic                          mode,
  input  logic [N-1:0][N-1:0][W-1:0]    mat_in,
  input  logic                          mat_valid,
  output logic                          mat_ready,
  output logic                          busy,
  output logic                          done,
  output logic [N-1:0][N-1:0][W-1:0]    product,
  output logic                          mm_en,
  output logic                          mm_rst,
  output logic                          mm_mode,
  output logic [N-1:0][N-1:0][W-1:0]    mm_dataa,
  output logic [N-1:0][N-1:0][W-1:0]    mm_datab,
  input  logic [N-1:0][N-1:0][W-1:0]    mm_result
);

  localparam int unsigned WCW = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;

  chain_state_t                 state_q, state_d;
  logic [LW-1:0]                len_q, len_d;
  logic                         mode_q, mode_d;
  logic [LW-1:0]                cnt_q, cnt_d;
  logic [WCW-1:0]               wait_q, wait_d;
  logic [N-1:0][N-1:0][W-1:0]   dataa_q, dataa_d;
  logic [N-1:0][N-1:0][W-1:0]   datab_q, datab_d;
  logic [N-1:0][N-1:0][W-1:0]   product_q, product_d;
  logic [N-1:0][N-1:0][W-1:0]   ident;
  logic [LW-1:0]                len_sat;
  logic                         wait_last;
  logic                         last_mul;

  // Identity matrix at this instance's size, used for empty chains.
  always_comb begin
    ident = '0;
    for (int i = 0; i < int'(N); i++) begin
      ident[i][i] = W'(1);
    end
  end

  assign len_sat   = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  assign wait_last = (wait_q == WCW'(MM_LAT - 1));
  // Count after this multiply's increment equals L-1.
  assign last_mul  = ((LW+1)'(cnt_q) + (LW+1)'(2)) == (LW+1)'(len_q);

  // Next-state, datapath capture and control outputs.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    dataa_d   = dataa_q;
    datab_d   = datab_q;
    product_d = product_q;
    mat_ready = 1'b0;
    mm_en     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len_sat;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = StClr;
        end
      end
      StClr: begin
        if (len_q == LW'(0)) begin
          product_d = ident;
          state_d   = StDone;
        end else begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        mat_ready = 1'b1;
        if (mat_valid) begin
          dataa_d = mat_in;
          if (len_q == LW'(1)) begin
            product_d = mat_in;
            state_d   = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        mat_ready = 1'b1;
        if (mat_valid) begin
          datab_d = mat_in;
          state_d = StMul;
        end
      end
      StMul: begin
        mm_en   = 1'b1;
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        mm_en = !wait_last;
        if (wait_last) begin
          dataa_d = mm_result;
          cnt_d   = cnt_q + LW'(1);
          if (last_mul) begin
            product_d = mm_result;
            state_d   = StDone;
          end else begin
            state_d = StFetch;
          end
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
      dataa_q   <= '0;
      datab_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      dataa_q   <= dataa_d;
      datab_q   <= datab_d;
      product_q <= product_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign mm_rst   = rst | (state_q == StClr);
  assign mm_mode  = mode_q;
  assign mm_dataa = dataa_q;
  assign mm_datab = datab_q;
  assign product  = product_q;

endmodule

// File: tb/tb_mat_chain_ctrl.sv
// Self-checking bench for mat_chain_ctrl with a behavioural mat_mult model.
module tb_mat_chain_ctrl;

  localparam int N       = 6;
  localparam int W       = 48;
  localparam int MAX_LEN = 6;
  localparam int MM_LAT  = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          mode;
  mat_t          mat_in;
  logic          mat_valid;
  logic          mat_ready, busy, done;
  mat_t          product;
  logic          mm_en, mm_rst, mm_mode;
  mat_t          mm_dataa, mm_datab, mm_result;

  int n_assert = 0;
  int n_fail   = 0;

  mat_t pipe [MM_LAT];
  mat_t mats [$];

  always #5 clk = ~clk;

  mat_chain_ctrl #(
    .N      (N),
    .W      (W),
    .MAX_LEN(MAX_LEN),
    .MM_LAT (MM_LAT),
    .LW     (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .mode     (mode),
    .mat_in   (mat_in),
    .mat_valid(mat_valid),
    .mat_ready(mat_ready),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .mm_en    (mm_en),
    .mm_rst   (mm_rst),
    .mm_mode  (mm_mode),
    .mm_dataa (mm_dataa),
    .mm_datab (mm_datab),
    .mm_result(mm_result)
  );

  function automatic mat_t mmul(mat_t a, mat_t b);
    mat_t r;
    logic [W-1:0] acc;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++) acc = acc + a[i][k] * b[k][j];
        r[i][j] = acc;
      end
    end
    return r;
  endfunction

  function automatic mat_t scal(logic [W-1:0] v);
    mat_t r;
    r = '0;
    for (int i = 0; i < N; i++) r[i][i] = v;
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = W'({$urandom, $urandom});
    return r;
  endfunction

  // mat_mult model: result of the first enabled cycle appears MM_LAT cycles later.
  always @(posedge clk) begin
    pipe[0] <= mm_en ? mmul(mm_dataa, mm_datab) : '0;
    for (int i = 1; i < MM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mm_result = pipe[MM_LAT-1];

  task automatic chk_int(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag, input mat_t obs, input mat_t exp);
    bit shown;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      shown = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (!shown && obs[i][j] !== exp[i][j]) begin
            shown = 1;
            $error("FAIL %s: element [%0d][%0d] observed %h expected %h",
                   tag, i, j, obs[i][j], exp[i][j]);
          end
    end
  endtask

  // Run one chain from the mats queue; cycle 0 is the cycle start is accepted.
  task automatic run_chain(input int len_in, input bit mode_in, input int stall_idx,
                           input int stall_n, input int glitch_cyc, input int abort_cyc);
    int eff, exp_done, done_cyc, idx, stall_left, en_run, bursts, bad_burst, bad_stable;
    int rst_cnt, rst_bad, late_done;
    bit ready_seen;
    mat_t exp_p, held_a, held_b;
    eff = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    exp_p = scal(W'(1));
    for (int k = 0; k < eff; k++) exp_p = mmul(exp_p, mats[k]);
    exp_done = (eff == 0) ? 2 : 3 + (eff - 1) * (2 + MM_LAT) + stall_n;
    done_cyc = -1; idx = 0; stall_left = stall_n; en_run = 0; bursts = 0;
    bad_burst = 0; bad_stable = 0; rst_cnt = 0; rst_bad = 0; ready_seen = 0;
    held_a = '0; held_b = '0;

    @(negedge clk);
    chk_int("idle_before_start", busy, 0);
    start = 1'b1;
    len = LW'(len_in);
    mode = mode_in;
    mat_valid = (mats.size() > 0);
    if (mat_valid) mat_in = mats[0];

    for (int cyc = 1; cyc <= exp_done + 20; cyc++) begin
      @(negedge clk);
      if (mm_rst) begin
        rst_cnt++;
        if (cyc != 1) rst_bad++;
      end
      if (mat_ready) ready_seen = 1;
      if (mm_en) begin
        if (en_run == 0) begin
          held_a = mm_dataa;
          held_b = mm_datab;
        end else if (mm_dataa !== held_a || mm_datab !== held_b) begin
          bad_stable++;
        end
        en_run++;
      end else if (en_run > 0) begin
        bursts++;
        if (en_run != MM_LAT) bad_burst++;
        en_run = 0;
      end
      if (cyc == 1) chk_int("mode_forwarded", mm_mode, mode_in);
      if (cyc == abort_cyc) begin
        chk_int("abort_during_multiply", mm_en, 1);
        rst = 1'b1;
        start = 1'b0;
        mat_valid = 1'b0;
        @(negedge clk);
        chk_int("abort_busy", busy, 0);
        chk_int("abort_done", done, 0);
        chk_int("abort_mm_rst", mm_rst, 1);
        chk_mat("abort_product_cleared", product, '0);
        rst = 1'b0;
        late_done = 0;
        repeat (30) begin
          @(negedge clk);
          if (done) late_done++;
        end
        chk_int("no_done_after_abort", late_done, 0);
        chk_int("idle_after_abort", busy, 0);
        return;
      end
      if (done) begin
        done_cyc = cyc;
        chk_mat("product_at_done", product, exp_p);
        break;
      end
      start = (cyc == glitch_cyc);
      if (start) len = LW'(1);
      if (stall_left > 0 && idx == stall_idx && mat_ready) begin
        mat_valid = 1'b0;
        stall_left--;
      end else begin
        mat_valid = (idx < mats.size());
        if (mat_valid) mat_in = mats[idx];
      end
      if (mat_ready && mat_valid) idx++;
    end

    start = 1'b0;
    mat_valid = 1'b0;
    chk_int("done_cycle", done_cyc, exp_done);
    chk_int("mats_consumed", idx, eff);
    chk_int("mm_rst_pulses", rst_cnt, 1);
    chk_int("mm_rst_outside_clr", rst_bad, 0);
    chk_int("mm_en_bursts", bursts, (eff > 1) ? eff - 1 : 0);
    chk_int("mm_en_burst_len", bad_burst, 0);
    chk_int("operand_stability", bad_stable, 0);
    chk_int("mat_ready_seen", ready_seen, (eff > 0));
    @(negedge clk);
    chk_int("done_single_cycle", done, 0);
    chk_int("idle_after_done", busy, 0);
    chk_mat("product_holds", product, exp_p);
  endtask

  initial begin
    mat_t m;
    int   l;
    rst = 1'b1; start = 1'b0; len = '0; mode = 1'b0; mat_in = '0; mat_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_int("reset_busy", busy, 0);
    chk_int("reset_done", done, 0);
    chk_int("reset_mat_ready", mat_ready, 0);
    chk_int("reset_mm_en", mm_en, 0);
    chk_int("reset_mm_mode", mm_mode, 0);
    chk_int("reset_mm_rst", mm_rst, 1);
    chk_mat("reset_product", product, '0);
    chk_mat("reset_mm_dataa", mm_dataa, '0);
    chk_mat("reset_mm_datab", mm_datab, '0);
    rst = 1'b0;

    // 2I * 3I * 5I with an ignored start pulse mid-chain.
    mats = {};
    mats.push_back(scal(W'(2)));
    mats.push_back(scal(W'(3)));
    mats.push_back(scal(W'(5)));
    run_chain(3, 1'b1, -1, 0, 5, -1);
    chk_mat("scalar_chain_30I", product, scal(W'(30)));

    // Single matrix passes straight through.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = W'(i * N + j);
    mats = {};
    mats.push_back(m);
    run_chain(1, 1'b0, -1, 0, -1, -1);

    // Empty chain yields identity and never requests data.
    mats = {};
    mats.push_back(rand_mat());
    run_chain(0, 1'b0, -1, 0, -1, -1);

    // Length 7 saturates to MAX_LEN.
    mats = {};
    for (int k = 0; k < 7; k++) mats.push_back(rand_mat());
    run_chain(7, 1'b1, -1, 0, -1, -1);

    // Non-commuting pair with a 5-cycle stall before the second matrix.
    mats = {};
    mats.push_back(rand_mat());
    mats.push_back(rand_mat());
    run_chain(2, 1'b0, 1, 5, -1, -1);

    // Random chains.
    for (int t = 0; t < 3; t++) begin
      l = $urandom_range(2, MAX_LEN);
      mats = {};
      for (int k = 0; k < l; k++) mats.push_back(rand_mat());
      run_chain(l, 1'($urandom_range(0, 1)), -1, 0, -1, -1);
    end

    // Reset during WAIT of an L=3 chain, then a fresh L=2 chain.
    mats = {};
    for (int k = 0; k < 3; k++) mats.push_back(rand_mat());
    run_chain(3, 1'b0, -1, 0, -1, 6);
    mats = {};
    for (int k = 0; k < 2; k++) mats.push_back(rand_mat());
    run_chain(2, 1'b1, -1, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
